// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector.
// Holds the overlap-mode enum and the reset-default configuration that
// makes the block power up as the legacy overlapping 1101 detector.
package seq_det_pkg;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } ovl_mode_e;

  localparam logic [3:0]  DEF_PATTERN = 4'b1101;
  localparam int unsigned DEF_LEN     = 4;
  localparam ovl_mode_e   DEF_OVERLAP = OVERLAP;

endpackage

// File: rtl/seq_det_prog_if.sv
// Signal bundle for seq_det_prog.
// master: drives serial data, qualifier, config load/fields and counter clear;
//         receives out, out_r, match_cnt, cfg_err.
// slave : the detector side of the same signals.
interface seq_det_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  import seq_det_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               in;
  logic               in_vld;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               cnt_clr;
  logic               out;
  logic               out_r;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  modport master (
    output in, in_vld, cfg_load, pattern, pat_len, overlap, cnt_clr,
    input  out, out_r, match_cnt, cfg_err
  );

  modport slave (
    input  in, in_vld, cfg_load, pattern, pat_len, overlap, cnt_clr,
    output out, out_r, match_cnt, cfg_err
  );

endinterface

// File: rtl/seq_det_prog_hist_sr.sv
// History shift register with fill counter for the sequence detector.
// Ports: clk, rst (async, active-high), i_shift (accept i_bit),
//        i_clr (sync clear, dominates i_shift), i_bit (serial bit),
//        o_hist (accepted bits, newest in bit 0), o_fill (valid bits, saturating).
module seq_hist_sr #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_shift,
  input  logic               i_clr,
  input  logic               i_bit,
  output logic [MAX_LEN-1:0] o_hist,
  output logic [LEN_W-1:0]   o_fill
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= {r_hist[MAX_LEN-2:0], i_bit};
      if (r_fill != FILL_MAX) r_fill <= r_fill + LEN_W'(1);
    end
  end

  assign o_hist = r_hist;
  assign o_fill = r_fill;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable Mealy serial sequence detector.
// Ports: clk, reset (async, active-high), bus (seq_det_prog_if.slave):
//   in/in_vld      qualified serial bit
//   cfg_load       capture pattern/pat_len/overlap into shadow registers
//   cnt_clr        synchronous clear of match_cnt (beats a same-cycle match)
//   out            same-cycle match pulse; out_r is its registered copy
//   match_cnt      saturating match count; cfg_err flags an illegal length
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic           clk,
  input logic           reset,
  seq_det_prog_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_pat_q;
  logic [LEN_W-1:0]   r_len_q;
  ovl_mode_e          r_ovl_q;
  logic               r_cfg_err;
  logic               r_out_r;
  logic [CNT_W-1:0]   r_match_cnt;

  logic [MAX_LEN-1:0] w_hist;
  logic [LEN_W-1:0]   w_fill;
  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN:0]   w_cand;
  logic               w_len_ok;
  logic               w_eq;
  logic               w_match;
  logic               w_shift;
  logic               w_clr;

  // Low len_q bits of the mask set: (1 << len_q) - 1.
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len_q);
    end
  end

  // The oldest history bit sits above the mask, so it never affects the compare.
  assign w_cand   = {w_hist, bus.in};
  assign w_eq     = ((w_cand ^ {1'b0, r_pat_q}) & {1'b0, w_mask}) == '0;
  assign w_len_ok = ({1'b0, w_fill} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, r_len_q};
  assign w_match  = bus.in_vld & ~bus.cfg_load & ~r_cfg_err & ~reset & w_len_ok & w_eq;

  assign w_shift  = bus.in_vld & ~bus.cfg_load;
  assign w_clr    = bus.cfg_load | (w_match & (r_ovl_q == NON_OVERLAP));

  seq_hist_sr #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk     (clk),
    .rst     (reset),
    .i_shift (w_shift),
    .i_clr   (w_clr),
    .i_bit   (bus.in),
    .o_hist  (w_hist),
    .o_fill  (w_fill)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat_q   <= MAX_LEN'(DEF_PATTERN);
      r_len_q   <= LEN_W'(DEF_LEN);
      r_ovl_q   <= DEF_OVERLAP;
      r_cfg_err <= 1'b0;
    end else if (bus.cfg_load) begin
      r_pat_q   <= bus.pattern;
      r_len_q   <= bus.pat_len;
      r_ovl_q   <= ovl_mode_e'(bus.overlap);
      r_cfg_err <= (bus.pat_len == '0) | (bus.pat_len > LEN_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_r     <= 1'b0;
      r_match_cnt <= '0;
    end else begin
      r_out_r <= w_match;
      if (bus.cnt_clr)                          r_match_cnt <= '0;
      else if (w_match && (r_match_cnt != '1))  r_match_cnt <= r_match_cnt + CNT_W'(1);
    end
  end

  assign bus.out       = w_match;
  assign bus.out_r     = r_out_r;
  assign bus.match_cnt = r_match_cnt;
  assign bus.cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_seq_det_prog.sv
module tb_seq_det_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  seq_det_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) sd ();

  seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic o;
    logic o_r;
    int   cnt;
    logic err;
  } exp_t;

  exp_t sb[$];

  int n_cmp;
  int n_err;
  int n_pulse;

  // Reference model: independent bitwise view of the accepted stream.
  logic [7:0] m_hist;
  int         m_n;
  logic [7:0] m_pat;
  int         m_len;
  logic       m_ovl;
  logic       m_err;
  int         m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist = '0;
    m_n    = 0;
    m_pat  = 8'b0000_1101;
    m_len  = 4;
    m_ovl  = 1'b1;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic step(input logic b, input logic v, input logic ld, input logic clr);
    exp_t e;
    logic eo;
    logic cb;
    @(negedge clk);
    sd.in       = b;
    sd.in_vld   = v;
    sd.cfg_load = ld;
    sd.cnt_clr  = clr;
    eo = 1'b0;
    if (v && !ld && !m_err && (m_n + 1 >= m_len)) begin
      eo = 1'b1;
      for (int k = 0; k < m_len; k++) begin
        cb = (k == 0) ? b : m_hist[k-1];
        if (cb !== m_pat[k]) eo = 1'b0;
      end
    end
    if (ld) begin
      m_pat  = sd.pattern;
      m_len  = int'(sd.pat_len);
      m_ovl  = sd.overlap;
      m_err  = (m_len == 0) || (m_len > MAX_LEN);
      m_hist = '0;
      m_n    = 0;
    end else if (v) begin
      if (eo && !m_ovl) begin
        m_hist = '0;
        m_n    = 0;
      end else begin
        m_hist = {m_hist[6:0], b};
        if (m_n < MAX_LEN) m_n++;
      end
    end
    if (clr)                         m_cnt = 0;
    else if (eo && m_cnt < CNT_MAX)  m_cnt++;
    sb.push_back('{o: eo, o_r: eo, cnt: m_cnt, err: m_err});

    #2;
    e = sb.pop_front();
    check_eq("out", 32'(sd.out), 32'(e.o));
    if (sd.out === 1'b1) n_pulse++;
    @(posedge clk);
    #1;
    check_eq("out_r", 32'(sd.out_r), 32'(e.o_r));
    check_eq("match_cnt", 32'(sd.match_cnt), 32'(e.cnt));
    check_eq("cfg_err", 32'(sd.cfg_err), 32'(e.err));
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    sd.pattern = pat;
    sd.pat_len = len;
    sd.overlap = ovl;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    // scramble the config pins: they must be ignored after the load
    sd.pattern = ~pat;
    sd.pat_len = 4'(len + 4'd3);
    sd.overlap = ~ovl;
  endtask

  task automatic clear_cnt();
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    sd.in       = 1'b1;
    sd.in_vld   = 1'b1;
    sd.cfg_load = 1'b0;
    sd.cnt_clr  = 1'b0;
    #2;
    check_eq("rst_out", 32'(sd.out), 32'd0);
    check_eq("rst_out_r", 32'(sd.out_r), 32'd0);
    check_eq("rst_cnt", 32'(sd.match_cnt), 32'd0);
    check_eq("rst_err", 32'(sd.cfg_err), 32'd0);
    model_reset();
    @(negedge clk);
    reset     = 1'b0;
    sd.in_vld = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_pulse = 0;
    reset = 1'b1;
    sd.in = 1'b0;
    sd.in_vld = 1'b0;
    sd.cfg_load = 1'b0;
    sd.pattern = '0;
    sd.pat_len = '0;
    sd.overlap = 1'b0;
    sd.cnt_clr = 1'b0;
    model_reset();

    do_reset();

    // Defaults: overlapping 1101
    n_pulse = 0;
    feed(16'b1101101, 7);
    check_eq("dflt_pulses", n_pulse, 2);
    check_eq("dflt_cnt", 32'(sd.match_cnt), 2);

    // Non-overlap 1101
    clear_cnt();
    load(8'b0000_1101, 4'd4, 1'b0);
    n_pulse = 0;
    feed(16'b1101101, 7);
    check_eq("novl_pulses", n_pulse, 1);
    check_eq("novl_cnt", 32'(sd.match_cnt), 1);

    // Length 8 with a 2-cycle gap
    clear_cnt();
    load(8'hA5, 4'd8, 1'b1);
    n_pulse = 0;
    feed(16'b1010, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    feed(16'b0101, 4);
    check_eq("len8_pulses", n_pulse, 1);
    check_eq("len8_cnt", 32'(sd.match_cnt), 1);

    // Config errors
    clear_cnt();
    load(8'h00, 4'd0, 1'b1);
    check_eq("len0_err", 32'(sd.cfg_err), 1);
    n_pulse = 0;
    feed(16'b0000_0000_0110_1101, 8);
    load(8'b0000_1101, 4'd9, 1'b1);
    check_eq("len9_err", 32'(sd.cfg_err), 1);
    feed(16'b1101101, 7);
    check_eq("err_pulses", n_pulse, 0);
    check_eq("err_cnt", 32'(sd.match_cnt), 0);
    load(8'b0000_0101, 4'd3, 1'b1);
    check_eq("len3_err", 32'(sd.cfg_err), 0);
    feed(16'b10101, 5);
    check_eq("len3_pulses", n_pulse, 2);

    // Saturation and clear-vs-match
    clear_cnt();
    load(8'h01, 4'd1, 1'b0);
    n_pulse = 0;
    feed(16'b11111, 5);
    check_eq("sat_pulses", n_pulse, 5);
    check_eq("sat_cnt", 32'(sd.match_cnt), CNT_MAX);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("clr_dom_cnt", 32'(sd.match_cnt), 0);

    // Random streams against the model
    load(8'($urandom), 4'd3, 1'b0);
    repeat (300) step(1'($urandom_range(1)), ($urandom_range(3) != 0), 1'b0, ($urandom_range(31) == 0));
    load(8'b0001_0110, 4'd5, 1'b1);
    repeat (300) step(1'($urandom_range(1)), ($urandom_range(3) != 0), 1'b0, ($urandom_range(31) == 0));

    // Reset mid-pattern
    do_reset();
    feed(16'b110, 3);
    do_reset();
    n_pulse = 0;
    feed(16'b1, 1);
    check_eq("rstmid_pulses", n_pulse, 0);
    feed(16'b1101, 4);
    check_eq("rstmid_match", n_pulse, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Programmable Mealy serial sequence detector, a parametrised successor to the fixed-pattern 1101 detector. Pattern and length (1..MAX_LEN) are runtime-loadable. Overlap or non-overlap detection is selectable. Adds an input-valid qualifier, a saturating match counter and a configuration-error flag. Sits on a serial bit stream next to the existing detector blocks and raises a same-cycle match pulse.

## Interface
- MAX_LEN, 8: maximum pattern length in bits, ≥2.
- CNT_W, 8: match counter width.
- LEN_W, $clog2(MAX_LEN+1): pattern-length field width (derived, not overridden).

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in  in  1  serial data bit.
- in_vld  in  1  qualifies `in`; the bit is consumed only when high.
- cfg_load  in  1  loads pattern, pat_len and overlap into shadow registers.
- pattern  in  MAX_LEN  pattern bits; pattern[pat_len-1] is the first bit received and pattern[0] is the last.
- pat_len  in  LEN_W  pattern length.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- out  out  1  Mealy match, combinational from `in`/`in_vld` and state.
- out_r  out  1  `out` registered; 1-cycle delayed copy.
- match_cnt  out  CNT_W  saturating count of matches.
- cfg_err  out  1  loaded pat_len is 0 or greater than MAX_LEN.

## Operation
- **State:**
  - hist[MAX_LEN-1:0]: shift register of accepted bits, newest in bit 0.
  - fill: number of valid bits in hist, saturating at MAX_LEN.
  - Shadow config registers: pat_q, len_q, ovl_q.
- **Match condition:**
  - Let cand = {hist[MAX_LEN-2:0], in}.
  - match = in_vld & !cfg_err & !cfg_load & (fill+1 ≥ len_q) & (cand[len_q-1:0] == pat_q[len_q-1:0]).
  - out = match.
- **On an accepted bit (in_vld=1, cfg_load=0):**
  - hist shifts in `in`.
  - fill increments (saturating at MAX_LEN).
  - If match and ovl_q=0, then hist is cleared and fill=0 instead.
- **Overlap mode:** history is retained through a match. With 1101 and stream 1101101, matches occur at bits 4 and 7.
- **cfg_load=1:**
  - Shadow registers load.
  - hist/fill clear.
  - cfg_err updates.
  - The current bit is discarded and out=0 that cycle.
- **cfg_err=1:**
  - out is held 0.
  - Bits still shift in.
  - The counter does not advance.
- **match_cnt:**
  - Increments on match.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr with a simultaneous match gives 0 (clear dominates).
- **in_vld=0:** state holds and out=0. Gaps in the stream are transparent.

## Timing
- **Reset values (asynchronous):**
  - hist=0, fill=0.
  - pat_q = 4'b1101 zero-extended, len_q=4, ovl_q=1.
  - cfg_err=0, out_r=0, match_cnt=0.
  - out is 0 while reset is asserted.
  - Out of reset the block behaves as the legacy overlapping 1101 detector.
- **Latency:**
  - out: 0 cycles, same cycle as the final pattern bit.
  - out_r and match_cnt: update on the next rising edge.
- **Shadow config:** takes effect from the cycle after cfg_load. Pattern/len/overlap pins are ignored at all other times.
- **Reset mid-pattern:** partial history is lost, and the next match requires a full pattern after reset deasserts.
- **pat_len=1:** every accepted bit equal to pat_q[0] matches. In non-overlap mode fill returns to 0 each match.

## Structure
- **Package seq_det_pkg:**
  - Reset-default constants: DEF_PATTERN=1101, DEF_LEN=4, DEF_OVERLAP=1.
  - typedef enum {NON_OVERLAP, OVERLAP} for the mode bit.
- **Sub-module seq_hist_sr:** MAX_LEN shift register with fill counter, shift-enable and synchronous clear. The top level holds config, compare, counter and output registers.
- **Compare:** a masked equality, mask = (1<<len_q)-1. No per-pattern FSM encoding.

## Test plan
- **Defaults after reset:** stream 1101101 with in_vld=1 → out=1 on the 4th and 7th bits; match_cnt=2; out_r follows one cycle later.
- **Non-overlap:** cfg_load with pattern=1101, len=4, overlap=0, then stream 1101101 → out=1 only on the 4th bit; match_cnt=1.
- **Length 8 with gaps:** pattern 8'hA5, len=8, stream 10100101 with in_vld dropped for 2 cycles mid-stream → exactly one out pulse, on the final bit.
- **Config errors:** cfg_load with len=0, then len=9 → cfg_err=1, no out pulses on any stream. Reload with len=3 → cfg_err=0.
- **Counter saturation and clear:** CNT_W=2, 5 matches → match_cnt saturates at 3. cnt_clr together with a match → match_cnt=0.
- **Reset mid-stream:** feed 110, assert reset for one cycle, then feed 1 → no match. Feed 1101 → match on the 4th bit.
